uart_lcd_writer: RTL

UART_LCD_WRITER -- requirements
Module: uart_lcd_writer

---
 rtl/lcd_pkg.sv | 50 +++++
 rtl/lcd_byte_fifo.sv | 58 +++++
 rtl/uart_lcd_writer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the UART-to-HD44780 writer: FSM encoding,
// controller command bytes and the control-character mapping.
package lcd_pkg;

    localparam logic [2:0] ST_PWR_WAIT = 3'd0;
    localparam logic [2:0] ST_INIT     = 3'd1;
    localparam logic [2:0] ST_IDLE     = 3'd2;
    localparam logic [2:0] ST_SETUP    = 3'd3;
    localparam logic [2:0] ST_E_HIGH   = 3'd4;
    localparam logic [2:0] ST_WAIT     = 3'd5;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef struct packed {
        logic       rs;
        logic [7:0] db;
    } lcd_word_t;

    function automatic lcd_word_t map_byte(input logic [7:0] b);
        lcd_word_t w;
        case (b)
            CH_FF:   w = '{rs: 1'b0, db: CMD_CLEAR};
            CH_CR:   w = '{rs: 1'b0, db: CMD_LINE1};
            CH_LF:   w = '{rs: 1'b0, db: CMD_LINE2};
            default: w = '{rs: 1'b1, db: b};
        endcase
        return w;
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] c;
        case (idx)
            2'd0:    c = CMD_FUNC_SET;
            2'd1:    c = CMD_DISP_ON;
            2'd2:    c = CMD_CLEAR;
            default: c = CMD_ENTRY;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_byte_fifo.sv
// Byte FIFO with show-ahead output; fullness is judged before a
// same-cycle pop, so a push into a full FIFO is always dropped.
module lcd_byte_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_lcd_writer.sv
// Buffers UART bytes and writes them to an HD44780 in 8-bit mode,
// running the power-up init sequence first.
module uart_lcd_writer
    import lcd_pkg::*;
#(
    parameter int FREQ         = 24_000_000,
    parameter int E_CYC        = 24,
    parameter int CMD_WAIT_CYC = 1200,
    parameter int CLR_WAIT_CYC = 48000,
    parameter int PWR_WAIT_CYC = 480000,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db,
    output logic       ready,
    output logic       overflow
);

    if (FREQ <= 0 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("uart_lcd_writer: bad FREQ or FIFO_DEPTH");
    end

    logic [2:0]  state;
    logic [19:0] cnt;
    logic [19:0] wait_last;
    logic [1:0]  init_idx;
    logic        init_done;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;

    assign fifo_pop = (state == ST_IDLE) && !fifo_empty;
    assign lcd_rw   = 1'b0;
    assign ready    = init_done && (state == ST_IDLE) && fifo_empty;

    // Clear needs the long settle time; every other write the short one.
    assign wait_last = (!lcd_rs && lcd_db == CMD_CLEAR)
                     ? 20'(CLR_WAIT_CYC - 1)
                     : 20'(CMD_WAIT_CYC - 1);

    lcd_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (rx_valid),
        .pop  (fifo_pop),
        .din  (rx_data),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_PWR_WAIT;
            cnt       <= '0;
            init_idx  <= '0;
            init_done <= 1'b0;
            overflow  <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_db    <= 8'h00;
        end else begin
            if (rx_valid && fifo_full)
                overflow <= 1'b1;
            case (state)
                ST_PWR_WAIT: begin
                    if (cnt == 20'(PWR_WAIT_CYC - 1)) begin
                        cnt   <= '0;
                        state <= ST_INIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_INIT: begin
                    lcd_rs <= 1'b0;
                    lcd_db <= init_cmd(init_idx);
                    state  <= ST_SETUP;
                end
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        {lcd_rs, lcd_db} <= map_byte(fifo_dout);
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    lcd_e <= 1'b1;
                    cnt   <= '0;
                    state <= ST_E_HIGH;
                end
                ST_E_HIGH: begin
                    if (cnt == 20'(E_CYC - 1)) begin
                        lcd_e <= 1'b0;
                        cnt   <= '0;
                        state <= ST_WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt == wait_last) begin
                        cnt <= '0;
                        if (init_done) begin
                            state <= ST_IDLE;
                        end else if (init_idx == 2'd3) begin
                            init_done <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            init_idx <= init_idx + 1'b1;
                            state    <= ST_INIT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_PWR_WAIT;
            endcase
        end
    end

endmodule
